// File: rtl/solver_scheduler.sv
// Round-robin scheduler for the shared crypto datapath (enc / dec / pwd).
// It issues one engine op at a time through a start/done handshake with a timeout.
//
// state | meaning
// IDLE  | no op in flight; arbitrate pending requests
// ISSUE | eng_start high for this cycle; timer cleared
// WAIT  | waiting for eng_done, timer counting toward TIMEOUT
// DONE  | result_valid strobe; release grant next cycle
module solver_scheduler #(
  parameter int PT_W    = 60,
  parameter int CT_W    = 78,
  parameter int TIMEOUT = 255
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            req_enc,
  input  logic [PT_W-1:0] enc_data,
  input  logic            req_dec,
  input  logic [CT_W-1:0] dec_data,
  input  logic            req_pwd,
  output logic [2:0]      grant,
  output logic [1:0]      eng_sel,
  output logic            eng_start,
  output logic [PT_W-1:0] eng_pt,
  output logic [CT_W-1:0] eng_ct,
  input  logic            eng_done,
  input  logic [CT_W-1:0] eng_res_ct,
  input  logic [PT_W-1:0] eng_res_pt,
  output logic [CT_W-1:0] result_ct,
  output logic [PT_W-1:0] result_pt,
  output logic            result_valid,
  output logic [1:0]      result_tag,
  output logic            result_err,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] SEL_ENC  = 2'b00;
  localparam logic [1:0] SEL_DEC  = 2'b01;
  localparam logic [1:0] SEL_PWD  = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t     state;
  logic [1:0] rr_last;
  logic [7:0] timer;
  logic [7:0] timer_inc;
  logic [2:0] req_v;
  logic       pick_valid;
  logic [1:0] pick;

  assign req_v     = {req_pwd, req_dec, req_enc};
  assign timer_inc = timer + 8'd1;

  // Search starts at the requester after the last one served.
  always_comb begin
    pick_valid = |req_v;
    pick       = SEL_ENC;
    case (rr_last)
      SEL_ENC: begin
        if (req_v[1])      pick = SEL_DEC;
        else if (req_v[2]) pick = SEL_PWD;
        else               pick = SEL_ENC;
      end
      SEL_DEC: begin
        if (req_v[2])      pick = SEL_PWD;
        else if (req_v[0]) pick = SEL_ENC;
        else               pick = SEL_DEC;
      end
      default: begin
        if (req_v[0])      pick = SEL_ENC;
        else if (req_v[1]) pick = SEL_DEC;
        else               pick = SEL_PWD;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      rr_last      <= SEL_PWD;
      timer        <= 8'd0;
      grant        <= 3'b000;
      eng_sel      <= SEL_IDLE;
      eng_start    <= 1'b0;
      eng_pt       <= '0;
      eng_ct       <= '0;
      result_ct    <= '0;
      result_pt    <= '0;
      result_valid <= 1'b0;
      result_tag   <= 2'b00;
      result_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant     <= 3'b001 << pick;
            eng_sel   <= pick;
            rr_last   <= pick;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            if (pick == SEL_ENC) eng_pt <= enc_data;
            if (pick == SEL_DEC) eng_ct <= dec_data;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_start <= 1'b0;
          timer     <= 8'd0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer_inc;
          // A done arriving on the terminal cycle still counts as success.
          if (eng_done) begin
            if (eng_sel == SEL_ENC) result_ct <= eng_res_ct;
            else                    result_pt <= eng_res_pt;
            result_err   <= 1'b0;
            result_valid <= 1'b1;
            result_tag   <= eng_sel;
            state        <= S_DONE;
          end else if (timer_inc == TIMEOUT_L) begin
            result_err   <= 1'b1;
            result_valid <= 1'b1;
            result_tag   <= eng_sel;
            state        <= S_DONE;
          end
        end
        default: begin
          grant        <= 3'b000;
          eng_sel      <= SEL_IDLE;
          result_valid <= 1'b0;
          result_err   <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_scheduler.sv
// Bench for solver_scheduler: vector table, directed corner cases, and random ops
// checked against a transaction-level round-robin and result-register model.
module tb_solver_scheduler;

  localparam int PT_W    = 60;
  localparam int CT_W    = 78;
  localparam int TIMEOUT = 255;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic            req_enc = 1'b0, req_dec = 1'b0, req_pwd = 1'b0;
  logic [PT_W-1:0] enc_data = '0;
  logic [CT_W-1:0] dec_data = '0;
  logic [2:0]      grant;
  logic [1:0]      eng_sel;
  logic            eng_start;
  logic [PT_W-1:0] eng_pt;
  logic [CT_W-1:0] eng_ct;
  logic            eng_done = 1'b0;
  logic [CT_W-1:0] eng_res_ct = '0;
  logic [PT_W-1:0] eng_res_pt = '0;
  logic [CT_W-1:0] result_ct;
  logic [PT_W-1:0] result_pt;
  logic            result_valid;
  logic [1:0]      result_tag;
  logic            result_err;
  logic            busy;

  solver_scheduler #(.PT_W(PT_W), .CT_W(CT_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_enc(req_enc), .enc_data(enc_data),
    .req_dec(req_dec), .dec_data(dec_data),
    .req_pwd(req_pwd),
    .grant(grant), .eng_sel(eng_sel), .eng_start(eng_start),
    .eng_pt(eng_pt), .eng_ct(eng_ct),
    .eng_done(eng_done), .eng_res_ct(eng_res_ct), .eng_res_pt(eng_res_pt),
    .result_ct(result_ct), .result_pt(result_pt),
    .result_valid(result_valid), .result_tag(result_tag),
    .result_err(result_err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: last served requester index and result registers.
  int              mdl_last = 2;
  logic [CT_W-1:0] mdl_ct = '0;
  logic [PT_W-1:0] mdl_pt = '0;

  typedef struct {
    logic [2:0]      reqs;
    logic [PT_W-1:0] ed;
    logic [CT_W-1:0] dd;
    int              dly;
    logic [CT_W-1:0] rct;
    logic [PT_W-1:0] rpt;
    logic [2:0]      exp_g;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] mdl_pick(input logic [2:0] reqs);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (mdl_last + k) % 3;
      if (reqs[idx]) return 3'b001 << idx;
    end
    return 3'b000;
  endfunction

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    return g[0] ? 2'b00 : (g[1] ? 2'b01 : 2'b10);
  endfunction

  function automatic logic [PT_W-1:0] rnd_pt();
    return PT_W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [CT_W-1:0] rnd_ct();
    return CT_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Waits for eng_start within a bounded window; returns the number of extra negedges.
  task automatic wait_start(output int n);
    n = 0;
    @(negedge Clk);
    while (!eng_start && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("start_seen", eng_start, 1'b1);
  endtask

  task automatic run_op(input logic [2:0] reqs, input logic [PT_W-1:0] ed,
                        input logic [CT_W-1:0] dd, input int dly,
                        input logic [CT_W-1:0] rct, input logic [PT_W-1:0] rpt,
                        input logic [2:0] exp_g);
    int   n;
    logic early;
    early    = 1'b0;
    req_enc  = reqs[0];
    req_dec  = reqs[1];
    req_pwd  = reqs[2];
    enc_data = ed;
    dec_data = dd;
    wait_start(n);
    chk("start_latency", n, 0);
    chk("grant", grant, exp_g);
    chk("eng_sel", eng_sel, sel_of(exp_g));
    chk("busy_active", busy, 1'b1);
    if (exp_g[0]) chk("eng_pt_latch", eng_pt, ed);
    if (exp_g[1]) chk("eng_ct_latch", eng_ct, dd);
    req_enc  = 1'b0;
    req_dec  = 1'b0;
    req_pwd  = 1'b0;
    enc_data = ~ed;
    dec_data = ~dd;
    repeat (1 + dly) begin
      @(negedge Clk);
      if (eng_start || result_valid) early = 1'b1;
    end
    eng_done   = 1'b1;
    eng_res_ct = rct;
    eng_res_pt = rpt;
    @(negedge Clk);
    eng_done   = 1'b0;
    eng_res_ct = rnd_ct();
    eng_res_pt = rnd_pt();
    if (exp_g[0]) mdl_ct = rct;
    else          mdl_pt = rpt;
    mdl_last = int'(sel_of(exp_g));
    chk("no_early_strobe", early, 1'b0);
    chk("result_valid", result_valid, 1'b1);
    chk("result_err_ok", result_err, 1'b0);
    chk("result_tag", result_tag, sel_of(exp_g));
    chk("result_ct", result_ct, mdl_ct);
    chk("result_pt", result_pt, mdl_pt);
    if (exp_g[0]) chk("eng_pt_frozen", eng_pt, ed);
    if (exp_g[1]) chk("eng_ct_frozen", eng_ct, dd);
    @(negedge Clk);
    chk("valid_one_cycle", result_valid, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("grant_released", grant, 3'b000);
    chk("eng_sel_idle", eng_sel, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] r, g;

    tbl[0] = '{3'b001, 60'h0_1234_5678_9ABC, 78'h0, 1, 78'h3FFF, 60'h0, 3'b001};
    tbl[1] = '{3'b111, 60'h111, 78'h222, 0, 78'h3A, 60'h5B, 3'b010};
    tbl[2] = '{3'b111, 60'h333, 78'h444, 0, 78'h3C, 60'h5D, 3'b100};
    tbl[3] = '{3'b111, 60'h555, 78'h666, 0, 78'h3E, 60'h5F, 3'b001};
    tbl[4] = '{3'b101, 60'h777, 78'h888, 2, 78'h40, 60'h61, 3'b100};
    tbl[5] = '{3'b110, 60'h999, 78'hAAA, 3, 78'h42, 60'h63, 3'b010};
    tbl[6] = '{3'b010, 60'hBBB, 78'hCCC, 0, 78'h44, 60'h65, 3'b010};
    tbl[7] = '{3'b011, 60'hDDD, 78'hEEE, 4, 78'h46, 60'h67, 3'b001};

    repeat (3) @(negedge Clk);
    chk("rst_grant", grant, 3'b000);
    chk("rst_eng_sel", eng_sel, 2'b11);
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result_ct", result_ct, '0);
    Rst_n = 1'b1;

    // Stray done while idle must be ignored.
    @(negedge Clk);
    eng_done = 1'b1; eng_res_ct = 78'h1111; eng_res_pt = 60'h2222;
    @(negedge Clk);
    eng_done = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      chk("idle_done_valid", result_valid, 1'b0);
      chk("idle_done_ct", result_ct, mdl_ct);
      chk("idle_done_pt", result_pt, mdl_pt);
    end

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].reqs, tbl[i].ed, tbl[i].dd, tbl[i].dly, tbl[i].rct, tbl[i].rpt, tbl[i].exp_g);

    // Timeout on a decrypt op, then a late done after it.
    req_dec  = 1'b1;
    dec_data = 78'h1;
    wait_start(n);
    chk("to_grant", grant, 3'b010);
    req_dec = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!result_valid && n < 300);
    mdl_last = 1;
    chk("timeout_latency", n, TIMEOUT + 1);
    chk("timeout_err", result_err, 1'b1);
    chk("timeout_tag", result_tag, 2'b01);
    chk("timeout_pt_kept", result_pt, mdl_pt);
    chk("timeout_ct_kept", result_ct, mdl_ct);
    chk("timeout_eng_ct", eng_ct, 78'h1);
    @(negedge Clk);
    chk("timeout_valid_clr", result_valid, 1'b0);
    chk("timeout_err_clr", result_err, 1'b0);
    chk("timeout_idle", busy, 1'b0);
    eng_done = 1'b1; eng_res_ct = 78'h3333; eng_res_pt = 60'h4444;
    @(negedge Clk);
    eng_done = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("late_done_valid", result_valid, 1'b0);
      chk("late_done_busy", busy, 1'b0);
      chk("late_done_pt", result_pt, mdl_pt);
      chk("late_done_ct", result_ct, mdl_ct);
    end

    for (int i = 0; i < 40; i++) begin
      r = 3'($urandom_range(1, 7));
      g = mdl_pick(r);
      run_op(r, rnd_pt(), rnd_ct(), int'($urandom_range(0, 5)), rnd_ct(), rnd_pt(), g);
    end

    // Reset while a password op is waiting on the engine.
    req_pwd = 1'b1;
    wait_start(n);
    chk("pwd_grant", grant, 3'b100);
    req_pwd = 1'b0;
    repeat (2) @(negedge Clk);
    req_dec = 1'b1;
    req_pwd = 1'b1;
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_grant", grant, 3'b000);
    chk("abort_eng_sel", eng_sel, 2'b11);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", result_valid, 1'b0);
    chk("abort_result_ct", result_ct, '0);
    chk("abort_result_pt", result_pt, '0);
    chk("abort_eng_pt", eng_pt, '0);
    chk("abort_eng_ct", eng_ct, '0);
    mdl_last = 2;
    mdl_ct   = '0;
    mdl_pt   = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    run_op(3'b110, 60'h5, 78'h7777, 1, 78'h12, 60'h34, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
